// File: rtl/tft_spi_arbiter.sv
// Round-robin arbiter and byte sequencer sitting between two TFT clients and the
// shared SPI byte engine: locks whole transactions, drives DC per byte, runs load/busy.
module tft_spi_arbiter #(
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_dc,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic        grant,
    output logic        active,
    output logic        spi_load,
    output logic [7:0]  spi_data,
    input  logic        spi_busy,
    output logic        tft_dc,
    output logic        err_timeout
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic             grant_q;
    logic             active_q;
    logic             spi_load_q;
    logic [7:0]       spi_data_q;
    logic             tft_dc_q;
    logic [1:0]       req_ready_q;
    logic             err_timeout_q;
    logic             last_served_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    logic             winner_d;
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_dc;
    logic             sel_last;

    // Only the locked requester's lane is ever looked at outside IDLE.
    always_comb begin
        sel_valid = grant_q ? req_valid[1]     : req_valid[0];
        sel_data  = grant_q ? req_data[15:8]   : req_data[7:0];
        sel_dc    = grant_q ? req_dc[1]        : req_dc[0];
        sel_last  = grant_q ? req_last[1]      : req_last[0];
        winner_d  = (req_valid == 2'b11) ? ~last_served_q : req_valid[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            active_q      <= 1'b0;
            spi_load_q    <= 1'b0;
            spi_data_q    <= 8'h00;
            tft_dc_q      <= 1'b0;
            req_ready_q   <= 2'b00;
            err_timeout_q <= 1'b0;
            last_served_q <= 1'b1;
            last_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            req_ready_q   <= 2'b00;
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q  <= winner_d;
                        active_q <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (sel_valid) begin
                        spi_data_q  <= sel_data;
                        tft_dc_q    <= sel_dc;
                        spi_load_q  <= 1'b1;
                        req_ready_q <= grant_q ? 2'b10 : 2'b01;
                        last_q      <= sel_last;
                        cnt_q       <= '0;
                        state_q     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        spi_load_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Engine never acknowledged: drop the whole transaction.
                        spi_load_q    <= 1'b0;
                        err_timeout_q <= 1'b1;
                        active_q      <= 1'b0;
                        last_served_q <= grant_q;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        if (last_q) begin
                            active_q      <= 1'b0;
                            last_served_q <= grant_q;
                            state_q       <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign grant       = grant_q;
    assign active      = active_q;
    assign spi_load    = spi_load_q;
    assign spi_data    = spi_data_q;
    assign tft_dc      = tft_dc_q;
    assign err_timeout = err_timeout_q;

endmodule
